dma_mem_arbiter_ram: RTL
========================

// Module: dma_mem_arbiter_ram
// PURPOSE
//  Memory-side responder for the DMA controller's mem_request/mem_grant master port, plus a CPU master port.
//  Arbitrates two masters onto one internal single-port word RAM; grants ownership, performs reads/writes.
//  Sits between dma_controller_top (mem_* ports) and the CPU data bus; one clock domain.
// PARAMETERS
//  DEPTH     1024  RAM words (32-bit); valid word addresses 0..DEPTH-1
//  MAX_HOLD  16    max consecutive granted cycles before forced hand-off when the other master waits (>=2)
// PORTS
//  clk             in   1   system clock, all logic rising-edge
//  reset           in   1   asynchronous, active-high reset
//  dma_mem_request in   1   DMA requests bus ownership (level, held while it wants the bus)
//  dma_mem_grant   out  1   DMA owns bus (registered)
//  dma_mem_addr    in   32  DMA word address
//  dma_mem_wdata   in   32  DMA write data
//  dma_mem_wr_en   in   1   DMA write strobe, honoured only with dma_mem_grant
//  dma_mem_rd_en   in   1   DMA read strobe, honoured only with dma_mem_grant
//  dma_mem_rdata   out  32  DMA read data
//  cpu_mem_request in   1   CPU requests bus ownership
//  cpu_mem_grant   out  1   CPU owns bus (registered)
//  cpu_mem_addr    in   32  CPU word address
//  cpu_mem_wdata   in   32  CPU write data
//  cpu_mem_wr_en   in   1   CPU write strobe
//  cpu_mem_rd_en   in   1   CPU read strobe
//  cpu_mem_rdata   out  32  CPU read data
//  addr_err        out  1   1-cycle pulse: honoured access with addr >= DEPTH
// BEHAVIOUR
//  Reset: all grants 0, both rdata 32'h0, addr_err 0, FSM IDLE, hold counter 0, last_owner=CPU. RAM array not cleared.
//  FSM states: IDLE, OWN_DMA, OWN_CPU, HANDOFF.
//   IDLE: only one requests -> grant it next cycle. Both -> grant the one != last_owner (round-robin).
//   OWN_x: request drops -> grant drops next cycle, go IDLE, last_owner=x.
//     hold counter counts granted cycles, saturating at MAX_HOLD.
//     counter==MAX_HOLD-1 and other requesting -> HANDOFF (both grants 0 next cycle).
//     Other not requesting -> owner keeps bus indefinitely.
//   HANDOFF: one cycle, both grants 0; then grant other master if still requesting, else IDLE. Counter cleared.
//  At least one cycle with both grants 0 between owners; grants never both 1.
//  Grant latency: request sampled in IDLE -> grant asserted on the following edge (1 cycle).
//  Access: sampled on edge where owner's grant==1 and strobe==1; strobes from non-owner ignored entirely.
//   Write: RAM[addr] <= wdata that edge.
//   Read: owner's rdata updates on that edge -> valid the cycle after rd_en (1-cycle latency), held until next read.
//   wr_en and rd_en together: write performed, read ignored, rdata unchanged.
//  Address: word index = addr; addr >= DEPTH -> write dropped, read returns 32'h0, addr_err pulses 1 cycle.
//  Strobe in the cycle grant drops (request already low) is not honoured if grant is 0 that cycle.
//  Reset mid-ownership: grants and rdata go 0 immediately (async); in-flight access lost; RAM keeps prior contents.
// TESTING
//  1. DMA request alone -> grant cycle+1; write 32'hDEADBEEF @5, read @5 -> dma_mem_rdata=32'hDEADBEEF one cycle after rd_en.
//  2. Both request first cycle after reset -> DMA granted (last_owner=CPU); DMA releases -> 1 idle cycle -> CPU granted.
//  3. MAX_HOLD=4, DMA holds request, CPU requests -> DMA grant high exactly 4 cycles, 1 HANDOFF cycle, then CPU grant.
//  4. CPU strobes wr_en @7 data 32'h1234 while DMA owns -> RAM[7] unchanged, DMA read @7 returns old value.
//  5. Owner writes addr DEPTH (1024) -> addr_err pulse 1 cycle, RAM unchanged; read @1024 -> rdata 32'h0, addr_err pulse.
//  6. Assert reset during DMA burst -> grants 0 same cycle; after release, previously written words read back intact.

Source files
------------

// File: rtl/dma_mem_arbiter_ram.sv
// ---------------------------------------------------------------------------
// dma_mem_arbiter_ram
//   Memory-side responder shared by the DMA controller and the CPU data bus.
//   Two masters compete for one single-port word RAM. A four-state arbiter
//   grants ownership to one master at a time. The owner's read and write
//   strobes are then serviced against the RAM.
//
//   Arbitration:
//     - A lone requester is granted one cycle after its request is seen idle.
//     - Simultaneous requests are resolved round-robin against the last owner.
//     - An owner that has held the bus for MAX_HOLD cycles while the other
//       master waits is forced through a one-cycle HANDOFF gap.
//     - A cycle with both grants low always separates two owners.
//
//   Ports:
//     clk, reset        rising-edge clock, asynchronous active-high reset
//     dma_mem_*         DMA master: request/grant, addr, wdata, wr_en, rd_en,
//                       rdata (1-cycle read latency, held until next read)
//     cpu_mem_*         CPU master, same signal set as the DMA port
//     addr_err          1-cycle pulse for an honoured access with addr >= DEPTH
// ---------------------------------------------------------------------------
module dma_mem_arbiter_ram #(
  parameter int DEPTH    = 1024,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_mem_request,
  output logic        dma_mem_grant,
  input  logic [31:0] dma_mem_addr,
  input  logic [31:0] dma_mem_wdata,
  input  logic        dma_mem_wr_en,
  input  logic        dma_mem_rd_en,
  output logic [31:0] dma_mem_rdata,
  input  logic        cpu_mem_request,
  output logic        cpu_mem_grant,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic        cpu_mem_wr_en,
  input  logic        cpu_mem_rd_en,
  output logic [31:0] cpu_mem_rdata,
  output logic        addr_err
);

  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(MAX_HOLD + 1);

  localparam logic [31:0]   DEPTH_W   = 32'(DEPTH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN_DMA, OWN_CPU, HANDOFF} state_t;

  state_t        state, state_nxt;
  logic          last_dma, last_dma_nxt;   // 1: DMA was the most recent owner
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic addr_in_range(input logic [31:0] a);
    return a < DEPTH_W;
  endfunction

  // ---- arbitration: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_dma      <= 1'b0;
      hold_cnt      <= '0;
      dma_mem_grant <= 1'b0;
      cpu_mem_grant <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_dma      <= last_dma_nxt;
      hold_cnt      <= hold_cnt_nxt;
      dma_mem_grant <= (state_nxt == OWN_DMA);
      cpu_mem_grant <= (state_nxt == OWN_CPU);
    end
  end

  // Forced hand-off fires once the owner has completed MAX_HOLD granted
  // cycles. Using >= instead of == means a master that starts waiting after
  // the counter has already saturated is still served promptly.
  always_comb begin
    state_nxt    = state;
    last_dma_nxt = last_dma;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (dma_mem_request && cpu_mem_request)
          state_nxt = last_dma ? OWN_CPU : OWN_DMA;
        else if (dma_mem_request)
          state_nxt = OWN_DMA;
        else if (cpu_mem_request)
          state_nxt = OWN_CPU;
      end
      OWN_DMA: begin
        if (!dma_mem_request) begin
          state_nxt    = IDLE;
          last_dma_nxt = 1'b1;
          hold_cnt_nxt = '0;
        end else if (cpu_mem_request && hold_cnt >= HOLD_LAST) begin
          state_nxt    = HANDOFF;
          last_dma_nxt = 1'b1;
          hold_cnt_nxt = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      OWN_CPU: begin
        if (!cpu_mem_request) begin
          state_nxt    = IDLE;
          last_dma_nxt = 1'b0;
          hold_cnt_nxt = '0;
        end else if (dma_mem_request && hold_cnt >= HOLD_LAST) begin
          state_nxt    = HANDOFF;
          last_dma_nxt = 1'b0;
          hold_cnt_nxt = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      HANDOFF: begin
        hold_cnt_nxt = '0;
        if (last_dma)
          state_nxt = cpu_mem_request ? OWN_CPU : IDLE;
        else
          state_nxt = dma_mem_request ? OWN_DMA : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- access stage p0: select the owner's strobes, drop everything else ----
  logic              wr_p0, rd_p0, vld_p0, ok_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [AW-1:0]     idx_p0;

  always_comb begin
    wr_p0    = 1'b0;
    rd_p0    = 1'b0;
    addr_p0  = '0;
    wdata_p0 = '0;
    if (dma_mem_grant) begin
      wr_p0    = dma_mem_wr_en;
      rd_p0    = dma_mem_rd_en & ~dma_mem_wr_en;  // write wins a combined strobe
      addr_p0  = dma_mem_addr;
      wdata_p0 = dma_mem_wdata;
    end else if (cpu_mem_grant) begin
      wr_p0    = cpu_mem_wr_en;
      rd_p0    = cpu_mem_rd_en & ~cpu_mem_wr_en;
      addr_p0  = cpu_mem_addr;
      wdata_p0 = cpu_mem_wdata;
    end
    vld_p0 = wr_p0 | rd_p0;
    ok_p0  = addr_in_range(addr_p0);
    idx_p0 = addr_p0[AW-1:0];
  end

  // ---- access stage p1: RAM write, read data and error pulse ----
  // The RAM array is intentionally never reset.
  always_ff @(posedge clk) begin
    if (wr_p0 && ok_p0)
      mem[idx_p0] <= wdata_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_mem_rdata <= '0;
      cpu_mem_rdata <= '0;
      addr_err      <= 1'b0;
    end else begin
      addr_err <= vld_p0 & ~ok_p0;
      if (rd_p0 && dma_mem_grant)
        dma_mem_rdata <= ok_p0 ? mem[idx_p0] : '0;
      if (rd_p0 && cpu_mem_grant)
        cpu_mem_rdata <= ok_p0 ? mem[idx_p0] : '0;
    end
  end

endmodule
